nota_teclado_enc: RTL and testbench
===================================

// Module: nota_teclado_enc
// PURPOSE
//  Converts the raw note keyboard (7 note keys DO..SI plus a sharp key) into the note code
//  {Tom, notas3, notas2, notas1} that drives the 7-segment note-display decoder.
//  Sits between the board push-buttons and the display decoder.
//  Synchronises, debounces and priority-encodes the keys.
//  Emits a one-cycle strobe per accepted key press.
// PARAMETERS
//  DEB_CICLOS  50000  consecutive identical synchronised samples needed to accept a key vector
//  CNT_W       16     debounce counter width; must satisfy 2**CNT_W > DEB_CICLOS
// PORTS
//  clk          in   1  single system clock, rising edge
//  rst_n        in   1  asynchronous reset, active-low
//  teclas       in   7  raw note keys, active-high, asynchronous; bit0=DO .. bit6=SI
//  tecla_tom    in   1  raw sharp key, active-high, asynchronous
//  Tom          out  1  sharp flag of the accepted note
//  notas3       out  1  note code bit 2 (MSB)
//  notas2       out  1  note code bit 1
//  notas1       out  1  note code bit 0 (LSB)
//  nota_valida  out  1  high while an accepted key is held
//  nota_strobe  out  1  one-cycle pulse when a new note code is accepted
//  erro_multi   out  1  high while more than one note key is in the accepted vector
// BEHAVIOUR
//  Clock and reset
//  - One clock, clk. Reset rst_n is asynchronous and active-low.
//  - Reset values: Tom=0, {notas3,notas2,notas1}=3'b111 (NOTA_NENHUMA), nota_valida=0, nota_strobe=0, erro_multi=0.
//  - Reset also clears the FSM to OCIOSO, the counter, and the synchroniser flops.
//  - Reset mid-debounce or mid-hold: the press is discarded and no strobe is issued.
//  Synchronisation and debounce
//  - All 8 key inputs pass through a 2-flop synchroniser, giving vec[7:0] = {tom, teclas}.
//  - The debounce counter compares vec with the previous sample.
//  - Any difference: counter <= 0. Otherwise the counter increments, saturating at DEB_CICLOS.
//  - A vector is "stable" in the cycle the counter reaches DEB_CICLOS-1.
//  FSM states
//  - OCIOSO: no key accepted. A nonzero vec -> CONFIRMA.
//  - CONFIRMA: counting a candidate vector.
//    - Stable with teclas!=0: latch the outputs, pulse nota_strobe, -> PRESSIONADA.
//    - vec returns to 0 before stable: -> OCIOSO, no strobe.
//  - PRESSIONADA: nota_valida=1. Any change of vec -> SOLTANDO, with the counter restarted.
//  - SOLTANDO:
//    - Stable vec==0: clear the outputs to reset values, -> OCIOSO.
//    - Stable teclas!=0 and the new code differs from the held code: relatch, strobe, -> PRESSIONADA.
//    - Stable teclas!=0 and the code is unchanged: -> PRESSIONADA, no strobe.
//  - nota_valida stays 1 throughout SOLTANDO until release is confirmed.
//  Encoding (constants in the shared package)
//  - DO=000, RE=001, MI=010, FA=011, SOL=100, LA=101, SI=110, NENHUMA=111.
//  - Multiple keys: the lowest index wins, and erro_multi=1 while the accepted vector holds >1 key.
//  - Tom = tom bit of the accepted vector, but forced to 0 for MI and SI (no sharp exists).
//  - Sharp key alone (teclas==0) is never accepted and stays in OCIOSO/CONFIRMA.
//  Timing
//  - All outputs are registered.
//  - Latency from the raw edge to nota_strobe = 2 (sync) + DEB_CICLOS + 1 cycles.
//  - nota_strobe never asserts in two consecutive cycles.
// STRUCTURE
//  - Shared package nota_pkg:
//    - 3-bit note code constants (NOTA_DO..NOTA_SI, NOTA_NENHUMA).
//    - FSM state encoding.
//    - Priority-encode function teclas->code.
//  - One natural sub-module: nota_debounce.
//    - Contains the 2-flop synchroniser plus counter.
//    - Outputs the stable vector and a one-cycle "estavel" pulse.
//    - Instantiated once, 8 bits wide.
//  - Top level holds the FSM, the encoder and the output registers.
// TESTING (benches run DEB_CICLOS=4)
//  1. Reset asserted mid-CONFIRMA -> all outputs at reset values immediately; no strobe after release.
//  2. Press RE (teclas=7'b0000010) clean for 10 cycles
//     -> exactly one strobe, 7 cycles after the edge; notas=001, Tom=0, nota_valida=1.
//  3. Press FA with tecla_tom bouncing (toggles every 2 cycles, then steady 1)
//     -> single strobe only after steady; notas=011, Tom=1.
//  4. Press MI+tecla_tom -> notas=010, Tom=0.
//     Press SOL+LA together -> notas=100, erro_multi=1.
//  5. Hold LA, release; a 2-cycle glitch back to LA during release
//     -> no new strobe; outputs return to 111/0 after the stable release.
//  6. Hold DO, slide to SI without a gap (overlap 1 cycle)
//     -> second strobe with notas=110; nota_valida never drops.

Source files
------------

// File: rtl/nota_pkg.sv
// Shared note-code constants, FSM state type and the key priority encoder
// used by the note keyboard encoder.
package nota_pkg;

  typedef logic [2:0] nota_t;

  localparam nota_t NOTA_DO      = 3'b000;
  localparam nota_t NOTA_RE      = 3'b001;
  localparam nota_t NOTA_MI      = 3'b010;
  localparam nota_t NOTA_FA      = 3'b011;
  localparam nota_t NOTA_SOL     = 3'b100;
  localparam nota_t NOTA_LA      = 3'b101;
  localparam nota_t NOTA_SI      = 3'b110;
  localparam nota_t NOTA_NENHUMA = 3'b111;

  typedef enum logic [1:0] {
    OCIOSO,
    CONFIRMA,
    PRESSIONADA,
    SOLTANDO
  } estado_t;

  // Lowest pressed key index wins; scanning from SI down leaves the lowest last.
  function automatic nota_t codifica(input logic [6:0] t);
    nota_t c;
    c = NOTA_NENHUMA;
    for (int unsigned i = 0; i < 7; i++) begin
      if (t[6-i]) c = nota_t'(6 - i);
    end
    return c;
  endfunction

  function automatic logic multi(input logic [6:0] t);
    return (t & (t - 7'd1)) != 7'd0;
  endfunction

endpackage

// File: rtl/nota_teclado_enc_if.sv
// Key inputs and note-code outputs between the board buttons and the
// note-display decoder.
interface nota_teclado_enc_if;
  logic [6:0] teclas;
  logic       tecla_tom;
  logic       Tom;
  logic       notas3;
  logic       notas2;
  logic       notas1;
  logic       nota_valida;
  logic       nota_strobe;
  logic       erro_multi;

  modport master (
    output teclas, tecla_tom,
    input  Tom, notas3, notas2, notas1, nota_valida, nota_strobe, erro_multi
  );

  modport slave (
    input  teclas, tecla_tom,
    output Tom, notas3, notas2, notas1, nota_valida, nota_strobe, erro_multi
  );
endinterface

// File: rtl/nota_debounce.sv
// Two-flop synchroniser plus a run-length counter; flags the cycle in which
// the synchronised vector has been unchanged long enough to be accepted.
module nota_debounce #(
  parameter int unsigned W          = 8,
  parameter int unsigned DEB_CICLOS = 50000,
  parameter int unsigned CNT_W      = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] bruto,
  output logic [W-1:0] vec,
  output logic         mudou,
  output logic         estavel
);

  logic [W-1:0]     s1, s2, prev;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= '0;
      s2   <= '0;
      prev <= '0;
      cnt  <= '0;
    end else begin
      s1   <= bruto;
      s2   <= s1;
      prev <= s2;
      if (s2 != prev)
        cnt <= '0;
      else if (cnt != CNT_W'(DEB_CICLOS))
        cnt <= cnt + CNT_W'(1);
    end
  end

  assign vec     = s2;
  assign mudou   = (s2 != prev);
  // Counter saturates above DEB_CICLOS-1, so this is a single-cycle pulse.
  assign estavel = !mudou && (cnt == CNT_W'(DEB_CICLOS - 1));

endmodule

// File: rtl/nota_teclado_enc.sv
// Note keyboard encoder: debounced key vector -> registered note code
// {Tom, notas3..1} with accept strobe, hold flag and multi-key flag.
module nota_teclado_enc
  import nota_pkg::*;
#(
  parameter int unsigned DEB_CICLOS = 50000,
  parameter int unsigned CNT_W      = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  nota_teclado_enc_if.slave bus
);

  logic [7:0] vec;
  logic       mudou, estavel;

  nota_debounce #(
    .W         (8),
    .DEB_CICLOS(DEB_CICLOS),
    .CNT_W     (CNT_W)
  ) u_debounce (
    .clk    (clk),
    .rst_n  (rst_n),
    .bruto  ({bus.tecla_tom, bus.teclas}),
    .vec    (vec),
    .mudou  (mudou),
    .estavel(estavel)
  );

  estado_t estado, estado_d;
  nota_t   nota_q, nota_d, cod_novo;
  logic    tom_q, tom_d, tom_novo;
  logic    valida_q, valida_d;
  logic    strobe_q, strobe_d;
  logic    erro_q, erro_d;

  assign cod_novo = codifica(vec[6:0]);
  assign tom_novo = vec[7] && (cod_novo != NOTA_MI) && (cod_novo != NOTA_SI);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado   <= OCIOSO;
      nota_q   <= NOTA_NENHUMA;
      tom_q    <= 1'b0;
      valida_q <= 1'b0;
      strobe_q <= 1'b0;
      erro_q   <= 1'b0;
    end else begin
      estado   <= estado_d;
      nota_q   <= nota_d;
      tom_q    <= tom_d;
      valida_q <= valida_d;
      strobe_q <= strobe_d;
      erro_q   <= erro_d;
    end
  end

  always_comb begin
    estado_d = estado;
    nota_d   = nota_q;
    tom_d    = tom_q;
    valida_d = valida_q;
    strobe_d = 1'b0;
    erro_d   = erro_q;
    unique case (estado)
      OCIOSO: begin
        if (vec != '0) estado_d = CONFIRMA;
      end
      CONFIRMA: begin
        if (vec == '0) begin
          estado_d = OCIOSO;
        end else if (estavel && vec[6:0] != '0) begin
          nota_d   = cod_novo;
          tom_d    = tom_novo;
          erro_d   = multi(vec[6:0]);
          valida_d = 1'b1;
          strobe_d = 1'b1;
          estado_d = PRESSIONADA;
        end
      end
      PRESSIONADA: begin
        if (mudou) estado_d = SOLTANDO;
      end
      SOLTANDO: begin
        if (estavel) begin
          if (vec == '0) begin
            nota_d   = NOTA_NENHUMA;
            tom_d    = 1'b0;
            erro_d   = 1'b0;
            valida_d = 1'b0;
            estado_d = OCIOSO;
          end else if (vec[6:0] != '0) begin
            // Same code re-held only refreshes the multi-key flag, no strobe.
            if ({tom_novo, cod_novo} != {tom_q, nota_q}) begin
              nota_d   = cod_novo;
              tom_d    = tom_novo;
              strobe_d = 1'b1;
            end
            erro_d   = multi(vec[6:0]);
            estado_d = PRESSIONADA;
          end
        end
      end
      default: estado_d = OCIOSO;
    endcase
  end

  assign bus.Tom                             = tom_q;
  assign {bus.notas3, bus.notas2, bus.notas1} = nota_q;
  assign bus.nota_valida                     = valida_q;
  assign bus.nota_strobe                     = strobe_q;
  assign bus.erro_multi                      = erro_q;

endmodule

// File: tb/tb_nota_teclado_enc.sv
// Directed bench for nota_teclado_enc with DEB_CICLOS=4: reset, clean and
// bouncing presses, multi-key, release glitch and key slide.
module tb_nota_teclado_enc;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  nota_teclado_enc_if bus();

  nota_teclado_enc #(
    .DEB_CICLOS(4),
    .CNT_W     (4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] code();
    return {bus.Tom, bus.notas3, bus.notas2, bus.notas1};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advances n cycles sampling at falling edges; reports strobe count,
  // 1-based index of first strobe, and whether nota_valida was ever low.
  task automatic run(input int n, output int nstr, output int first, output logic dropped);
    nstr    = 0;
    first   = 0;
    dropped = 1'b0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (bus.nota_strobe === 1'b1) begin
        nstr++;
        if (first == 0) first = i;
      end
      if (bus.nota_valida !== 1'b1) dropped = 1'b1;
    end
  endtask

  initial begin
    int   ns, fs, ns2, fs2, tot;
    logic dr, dr2;

    rst_n         = 1'b0;
    bus.teclas    = '0;
    bus.tecla_tom = 1'b0;
    @(negedge clk);
    run(2, ns, fs, dr);
    chk("reset_code",   32'(code()),          32'h7);
    chk("reset_valida", 32'(bus.nota_valida), 32'h0);
    chk("reset_strobe", 32'(bus.nota_strobe), 32'h0);
    chk("reset_erro",   32'(bus.erro_multi),  32'h0);
    rst_n = 1'b1;
    run(3, ns, fs, dr);

    // Reset mid-CONFIRMA
    bus.teclas = 7'b0000010;
    run(4, ns, fs, dr);
    chk("pre_reset_no_strobe", 32'(ns), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_code",   32'(code()),          32'h7);
    chk("midrst_valida", 32'(bus.nota_valida), 32'h0);
    chk("midrst_strobe", 32'(bus.nota_strobe), 32'h0);
    bus.teclas = '0;
    run(2, ns, fs, dr);
    rst_n = 1'b1;
    run(10, ns, fs, dr);
    chk("midrst_no_strobe_after", 32'(ns), 32'd0);

    // Clean RE press
    bus.teclas = 7'b0000010;
    run(10, ns, fs, dr);
    chk("re_strobes", 32'(ns),              32'd1);
    chk("re_latency", 32'(fs),              32'd7);
    chk("re_code",    32'(code()),          32'h1);
    chk("re_valida",  32'(bus.nota_valida), 32'h1);
    chk("re_erro",    32'(bus.erro_multi),  32'h0);
    bus.teclas = '0;
    run(10, ns, fs, dr);
    chk("re_rel_strobes", 32'(ns),              32'd0);
    chk("re_rel_code",    32'(code()),          32'h7);
    chk("re_rel_valida",  32'(bus.nota_valida), 32'h0);

    // FA with bouncing sharp key
    tot = 0;
    bus.teclas = 7'b0001000;
    for (int k = 0; k < 4; k++) begin
      bus.tecla_tom = (k % 2 == 0);
      run(2, ns, fs, dr);
      tot += ns;
    end
    chk("fa_bounce_no_strobe", 32'(tot), 32'd0);
    bus.tecla_tom = 1'b1;
    run(10, ns, fs, dr);
    chk("fa_strobes", 32'(ns),     32'd1);
    chk("fa_latency", 32'(fs),     32'd7);
    chk("fa_code",    32'(code()), 32'hB);
    bus.teclas    = '0;
    bus.tecla_tom = 1'b0;
    run(10, ns, fs, dr);
    chk("fa_rel_code", 32'(code()), 32'h7);

    // MI with sharp: sharp suppressed
    bus.teclas    = 7'b0000100;
    bus.tecla_tom = 1'b1;
    run(10, ns, fs, dr);
    chk("mi_strobes", 32'(ns),     32'd1);
    chk("mi_code",    32'(code()), 32'h2);
    bus.teclas    = '0;
    bus.tecla_tom = 1'b0;
    run(10, ns, fs, dr);

    // SOL+LA together
    bus.teclas = 7'b0110000;
    run(10, ns, fs, dr);
    chk("multi_strobes", 32'(ns),             32'd1);
    chk("multi_code",    32'(code()),         32'h4);
    chk("multi_erro",    32'(bus.erro_multi), 32'h1);
    bus.teclas = '0;
    run(10, ns, fs, dr);
    chk("multi_rel_erro", 32'(bus.erro_multi), 32'h0);

    // LA release with a 2-cycle glitch
    bus.teclas = 7'b0100000;
    run(10, ns, fs, dr);
    chk("la_code", 32'(code()), 32'h5);
    bus.teclas = '0;
    run(2, ns, fs, dr);
    bus.teclas = 7'b0100000;
    run(2, ns2, fs2, dr2);
    chk("la_glitch_strobes", 32'(ns + ns2),    32'd0);
    chk("la_glitch_valida",  32'(dr | dr2),    32'd0);
    bus.teclas = '0;
    run(10, ns, fs, dr);
    chk("la_rel_strobes", 32'(ns),              32'd0);
    chk("la_rel_code",    32'(code()),          32'h7);
    chk("la_rel_valida",  32'(bus.nota_valida), 32'h0);

    // Slide DO -> SI with one cycle of overlap
    bus.teclas = 7'b0000001;
    run(10, ns, fs, dr);
    chk("do_code", 32'(code()), 32'h0);
    bus.teclas = 7'b1000001;
    run(1, ns, fs, dr);
    bus.teclas = 7'b1000000;
    run(10, ns2, fs2, dr2);
    chk("slide_strobes", 32'(ns + ns2), 32'd1);
    chk("slide_code",    32'(code()),   32'h6);
    chk("slide_valida",  32'(dr | dr2), 32'd0);
    bus.teclas = '0;
    run(10, ns, fs, dr);
    chk("slide_rel_code", 32'(code()), 32'h7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
